bsg_credit_return_batcher: RTL and testbench

BSG_CREDIT_RETURN_BATCHER -- requirements
Module: bsg_credit_return_batcher

---
 rtl/bsg_credit_return_batcher_pkg.sv | 15 +
 rtl/bsg_credit_return_batcher_if.sv | 29 ++
 rtl/bsg_counter_up_down_variable.sv | 21 ++
 rtl/bsg_credit_return_batcher.sv | 109 ++++++++++
 tb/tb_bsg_credit_return_batcher.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bsg_credit_return_batcher_pkg.sv
// Shared types and default parameters for the credit return batcher.
package bsg_credit_return_batcher_pkg;

  localparam int unsigned max_step_default_lp    = 2;
  localparam int unsigned batch_default_lp       = 8;
  localparam int unsigned timeout_default_lp     = 16;
  localparam int unsigned max_pending_default_lp = 100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } batch_state_e;

endpackage

// File: rtl/bsg_credit_return_batcher_if.sv
// Credit return / release bus between the consumer side and the batcher.
interface bsg_credit_return_batcher_if
  import bsg_credit_return_batcher_pkg::*;
#(
  parameter int unsigned max_step_p    = max_step_default_lp,
  parameter int unsigned max_pending_p = max_pending_default_lp
);

  localparam int unsigned step_w_lp = $clog2(max_step_p + 1);
  localparam int unsigned pend_w_lp = $clog2(max_pending_p + 1);

  logic [step_w_lp-1:0] credit_i;
  logic                 flush_i;
  logic [step_w_lp-1:0] up_o;
  logic [pend_w_lp-1:0] pending_o;
  logic                 busy_o;
  logic                 overflow_o;

  modport master (
    output credit_i, flush_i,
    input  up_o, pending_o, busy_o, overflow_o
  );

  modport slave (
    input  credit_i, flush_i,
    output up_o, pending_o, busy_o, overflow_o
  );

endinterface

// File: rtl/bsg_counter_up_down_variable.sv
// Up/down counter that adds up_i and subtracts down_i every cycle.
module bsg_counter_up_down_variable #(
  parameter int unsigned max_val_p  = 100000,
  parameter int unsigned init_val_p = 0,
  parameter int unsigned max_step_p = 2,
  localparam int unsigned step_w_lp = $clog2(max_step_p + 1),
  localparam int unsigned cnt_w_lp  = $clog2(max_val_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [step_w_lp-1:0] up_i,
  input  logic [step_w_lp-1:0] down_i,
  output logic [cnt_w_lp-1:0]  count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) count_o <= cnt_w_lp'(init_val_p);
    else         count_o <= count_o + cnt_w_lp'(up_i) - cnt_w_lp'(down_i);
  end

endmodule

// File: rtl/bsg_credit_return_batcher.sv
// Credit return batcher: holds returned credits and releases them in bursts of
// up to max_step_p per cycle once a batch fills, a timeout expires, or on flush.
module bsg_credit_return_batcher
  import bsg_credit_return_batcher_pkg::*;
#(
  parameter int unsigned max_step_p    = max_step_default_lp,
  parameter int unsigned batch_p       = batch_default_lp,
  parameter int unsigned timeout_p     = timeout_default_lp,
  parameter int unsigned max_pending_p = max_pending_default_lp
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  bsg_credit_return_batcher_if.slave io
);

  localparam int unsigned step_w_lp  = $clog2(max_step_p + 1);
  localparam int unsigned pend_w_lp  = $clog2(max_pending_p + 1);
  localparam int unsigned sum_w_lp   = pend_w_lp + 1;
  localparam int unsigned timer_w_lp = $clog2(timeout_p + 1);

  batch_state_e          state_r, state_n;
  logic [timer_w_lp-1:0] timer_r, timer_n;
  logic [step_w_lp-1:0]  up_r, up_n;
  logic [step_w_lp-1:0]  accept;
  logic [pend_w_lp-1:0]  pending, pending_n;
  logic [sum_w_lp-1:0]   sum;
  logic                  sat;
  logic                  busy_r;
  logic                  overflow_r;

  // Clip incoming credits so the pending count never exceeds its capacity
  always_comb begin
    sum       = {1'b0, pending} + sum_w_lp'(io.credit_i) - sum_w_lp'(up_r);
    sat       = (sum > sum_w_lp'(max_pending_p));
    accept    = io.credit_i;
    pending_n = sum[pend_w_lp-1:0];
    if (sat) begin
      accept    = step_w_lp'(sum_w_lp'(max_pending_p) - {1'b0, pending} + sum_w_lp'(up_r));
      pending_n = pend_w_lp'(max_pending_p);
    end
  end

  bsg_counter_up_down_variable #(
    .max_val_p  (max_pending_p),
    .init_val_p (0),
    .max_step_p (max_step_p)
  ) pending_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (accept),
    .down_i  (up_r),
    .count_o (pending)
  );

  // Next state, timer and next release amount
  always_comb begin
    state_n = state_r;
    timer_n = timer_r;
    up_n    = '0;
    unique case (state_r)
      IDLE: begin
        timer_n = '0;
        if (io.credit_i != '0) state_n = io.flush_i ? DRAIN : ACCUM;
      end
      ACCUM: begin
        timer_n = timer_r + timer_w_lp'(1);
        if ((32'(pending) >= batch_p) ||
            (timer_r == timer_w_lp'(timeout_p - 1)) ||
            io.flush_i)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (pending_n == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == DRAIN)
      up_n = (32'(pending_n) > max_step_p) ? step_w_lp'(max_step_p)
                                            : step_w_lp'(pending_n);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      timer_r    <= '0;
      up_r       <= '0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      timer_r    <= timer_n;
      up_r       <= up_n;
      busy_r     <= (state_n != IDLE);
      overflow_r <= overflow_r | sat;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (32'(io.credit_i) <= max_step_p)
        else $error("bsg_credit_return_batcher: credit_i exceeds max_step_p");
  end

  assign io.up_o       = up_r;
  assign io.pending_o  = pending;
  assign io.busy_o     = busy_r;
  assign io.overflow_o = overflow_r;

endmodule

// File: tb/tb_bsg_credit_return_batcher.sv
// Directed and random checks of the credit return batcher against a cycle model.
module tb_bsg_credit_return_batcher;
  import bsg_credit_return_batcher_pkg::*;

  localparam int STEP  = 2;
  localparam int BATCH = 8;
  localparam int TMO   = 16;
  localparam int MAXP  = 100000;
  localparam int MAXP2 = 9;

  logic clk = 1'b0;
  logic rst;

  bsg_credit_return_batcher_if #(.max_step_p(STEP), .max_pending_p(MAXP))  io ();
  bsg_credit_return_batcher_if #(.max_step_p(STEP), .max_pending_p(MAXP2)) io2 ();

  bsg_credit_return_batcher #(
    .max_step_p(STEP), .batch_p(BATCH), .timeout_p(TMO), .max_pending_p(MAXP)
  ) dut (
    .clk_i(clk), .reset_i(rst), .io(io)
  );

  // Small-capacity instance so saturation is reachable
  bsg_credit_return_batcher #(
    .max_step_p(STEP), .batch_p(100), .timeout_p(TMO), .max_pending_p(MAXP2)
  ) dut_sat (
    .clk_i(clk), .reset_i(rst), .io(io2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: credits held, whether holding or releasing, age of the hold
  int    m_pend, m_up, m_age;
  bit    m_accum, m_drain, m_ovf;
  longint acc_sum, up_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int c, input bit f, input bit r);
    int total, acc;
    if (r) begin
      m_pend = 0; m_up = 0; m_age = 0; m_accum = 0; m_drain = 0; m_ovf = 0;
      acc_sum = 0; up_sum = 0;
      return;
    end
    total = m_pend + c - m_up;
    acc   = c;
    if (total > MAXP) begin
      acc   = c - (total - MAXP);
      total = MAXP;
      m_ovf = 1;
    end
    acc_sum += acc;
    if (m_accum) begin
      if (m_pend >= BATCH || m_age == TMO - 1 || f) begin
        m_accum = 0; m_drain = 1;
      end else m_age++;
    end else if (m_drain) begin
      if (total == 0) m_drain = 0;
    end else if (c != 0) begin
      if (f) m_drain = 1;
      else begin m_accum = 1; m_age = 0; end
    end
    m_pend = total;
    m_up   = m_drain ? ((m_pend < STEP) ? m_pend : STEP) : 0;
  endtask

  task automatic cycle(input int c, input bit f, input bit r);
    io.credit_i = 2'(c);
    io.flush_i  = f;
    rst         = r;
    model_step(c, f, r);
    @(posedge clk);
    #1;
    if (!r) up_sum += longint'(io.up_o);
    check("pending", 32'(io.pending_o), m_pend);
    check("up", 32'(io.up_o), m_up);
    check("busy", 32'(io.busy_o), 32'(m_accum | m_drain));
    check("overflow", 32'(io.overflow_o), 32'(m_ovf));
  endtask

  int n, cnt, lat, up2;
  int c;
  bit f, r;
  logic [31:0] hold;

  initial begin
    io.credit_i  = '0; io.flush_i  = 1'b0;
    io2.credit_i = '0; io2.flush_i = 1'b0;
    rst = 1'b1;

    // Reset, with credits offered during reset that must be ignored
    cycle(0, 0, 1);
    cycle(2, 1, 1);
    check("rst_pending2", 32'(io2.pending_o), 0);
    check("rst_overflow2", 32'(io2.overflow_o), 0);

    // Single credit: held for the full timeout, then released
    cycle(1, 0, 0);
    check("single_pending", 32'(io.pending_o), 1);
    check("single_busy", 32'(io.busy_o), 1);
    lat = 1;
    while (io.up_o == 0 && lat < 40) begin cycle(0, 0, 0); lat++; end
    check("single_latency", lat, TMO + 1);
    check("single_up", 32'(io.up_o), 1);
    cycle(0, 0, 0);
    check("single_idle_busy", 32'(io.busy_o), 0);
    check("single_idle_pending", 32'(io.pending_o), 0);
    check("sb_single", 32'(up_sum), 32'(acc_sum));

    // Flush with nothing pending does nothing
    cycle(0, 1, 0);
    check("flush_empty_busy", 32'(io.busy_o), 0);

    // Batch threshold
    for (int i = 0; i < 4; i++) cycle(2, 0, 0);
    check("batch_pending", 32'(io.pending_o), 8);
    check("batch_accum_up", 32'(io.up_o), 0);
    n = 0; cnt = 0;
    do begin
      cycle(0, 0, 0);
      if (io.up_o == 2) cnt++;
      n++;
    end while (io.busy_o && n < 20);
    check("batch_up_cycles", cnt, 4);
    check("batch_drain_len", n, 5);
    check("sb_batch", 32'(up_sum), 32'(acc_sum));

    // Flush while accumulating
    cycle(2, 0, 0);
    cycle(1, 0, 0);
    check("flush_pending", 32'(io.pending_o), 3);
    cycle(0, 1, 0);
    check("flush_up0", 32'(io.up_o), 2);
    cycle(0, 0, 0);
    check("flush_up1", 32'(io.up_o), 1);
    cycle(0, 0, 0);
    check("flush_idle", 32'(io.busy_o), 0);
    check("flush_up2", 32'(io.up_o), 0);
    check("sb_flush", 32'(up_sum), 32'(acc_sum));

    // Credits arriving during drain extend it at constant pending
    for (int i = 0; i < 4; i++) cycle(2, 0, 0);
    cycle(2, 0, 0);
    hold = 32'(io.pending_o);
    check("extend_entry", hold, 10);
    for (int i = 0; i < 4; i++) begin
      cycle(2, 0, 0);
      check("extend_pending", 32'(io.pending_o), hold);
      check("extend_up", 32'(io.up_o), 2);
      check("extend_busy", 32'(io.busy_o), 1);
    end
    n = 0;
    while (io.busy_o && n < 20) begin cycle(0, 0, 0); n++; end
    check("extend_tail", n, 5);
    check("sb_extend", 32'(up_sum), 32'(acc_sum));

    // Reset in the middle of a drain discards pending credits
    for (int i = 0; i < 4; i++) cycle(2, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("rstd_pending", 32'(io.pending_o), 6);
    cycle(2, 0, 1);
    check("rstd_after_pending", 32'(io.pending_o), 0);
    check("rstd_after_up", 32'(io.up_o), 0);
    check("rstd_after_busy", 32'(io.busy_o), 0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 7) == 0);
      c = int'($urandom_range(0, 2));
      cycle(c, f, r);
    end
    n = 0;
    while ((m_accum || m_drain) && n < 40) begin cycle(0, 0, 0); n++; end
    check("rand_quiesce", 32'(io.busy_o), 0);
    check("sb_random", 32'(up_sum), 32'(acc_sum));

    // Saturation on the small-capacity instance
    cycle(0, 0, 1);
    io2.credit_i = 2'd2;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    check("sat_pre_pending", 32'(io2.pending_o), 8);
    check("sat_pre_overflow", 32'(io2.overflow_o), 0);
    cycle(0, 0, 0);
    check("sat_pending", 32'(io2.pending_o), MAXP2);
    check("sat_overflow", 32'(io2.overflow_o), 1);
    io2.credit_i = 2'd0;
    up2 = 0; n = 0;
    while (io2.pending_o != 0 && n < 40) begin
      cycle(0, 0, 0);
      up2 += int'(io2.up_o);
      n++;
    end
    cycle(0, 0, 0);
    check("sat_released", up2, MAXP2);
    check("sat_idle", 32'(io2.busy_o), 0);
    check("sat_sticky", 32'(io2.overflow_o), 1);
    cycle(0, 0, 1);
    check("sat_cleared", 32'(io2.overflow_o), 0);
    check("sat_cleared_pending", 32'(io2.pending_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
